// File: rtl/buzz_ctrl.sv
// Buzzer pattern controller: three fixed beep patterns with priority
// preemption, per-pattern pending flags, a 1 ms timebase and a square-wave
// tone generator whose half-period depends on the running pattern.
module buzz_ctrl #(
    parameter int TICK_DIV = 50000,
    parameter int HP0      = 20000,
    parameter int HP1      = 25000,
    parameter int HP2      = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       stop,
    output logic       buz,
    output logic       busy,
    output logic [1:0] active,
    output logic       done
);

    localparam int HP_MAX = (HP0 > HP1) ? ((HP0 > HP2) ? HP0 : HP2)
                                        : ((HP1 > HP2) ? HP1 : HP2);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = (HP_MAX > 1) ? $clog2(HP_MAX) : 1;

    // Phase lengths in milliseconds
    localparam logic [7:0] P0_ON_MS  = 8'd50;
    localparam logic [7:0] P1_ON_MS  = 8'd200;
    localparam logic [7:0] P2_ON_MS  = 8'd100;
    localparam logic [7:0] OFF_MS    = 8'd100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      pat_q, pat_d;
    logic [2:0]      pend_q, pend_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [7:0]      ms_q, ms_d;
    logic [HW-1:0]   hp_q, hp_d;
    logic [1:0]      beep_q, beep_d;
    logic            buz_q, buz_d;
    logic            done_q, done_d;

    logic [2:0]      eff_pend;
    logic            hi_valid;
    logic [1:0]      hi_idx;
    logic [2:0]      run_mask;
    logic [7:0]      phase_ms;
    logic [HW-1:0]   hp_last;
    logic            tick;
    logic            phase_end;
    logic            start;
    logic            to_idle;
    logic            restart;

    // Decode highest pending request and the current phase's limits
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        eff_pend = pend_q & ~{stop, 2'b00};
        hi_valid = |eff_pend;
        if (eff_pend[2])      hi_idx = 2'd2;
        else if (eff_pend[1]) hi_idx = 2'd1;
        else                  hi_idx = 2'd0;

        run_mask = (state_q != S_IDLE) ? (3'b001 << pat_q) : 3'b000;

        phase_ms = OFF_MS;
        if (state_q == S_ON) begin
            case (pat_q)
                2'd0:    phase_ms = P0_ON_MS;
                2'd1:    phase_ms = P1_ON_MS;
                default: phase_ms = P2_ON_MS;
            endcase
        end

        case (pat_q)
            2'd0:    hp_last = HW'(HP0 - 1);
            2'd1:    hp_last = HW'(HP1 - 1);
            default: hp_last = HW'(HP2 - 1);
        endcase

        tick      = (pre_q == PW'(TICK_DIV - 1));
        phase_end = (state_q != S_IDLE) && tick && (ms_q == phase_ms - 8'd1);
    end

    // Next-state, pending flags, counters and tone output
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        beep_d  = beep_q;
        done_d  = 1'b0;
        start   = 1'b0;
        to_idle = 1'b0;
        restart = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hi_valid) start = 1'b1;
            end
            default: begin
                if (pat_q == 2'd2 && stop) begin
                    // Cancelled alarm: hand over to whatever is waiting
                    if (hi_valid) start = 1'b1;
                    else          to_idle = 1'b1;
                end else if (hi_valid && hi_idx > pat_q) begin
                    // Higher-priority pattern aborts the running one
                    start = 1'b1;
                end else if (phase_end) begin
                    if (state_q == S_ON) begin
                        if (pat_q != 2'd2 && beep_q == 2'd1) begin
                            done_d = 1'b1;
                            if (hi_valid) start = 1'b1;
                            else          to_idle = 1'b1;
                        end else begin
                            state_d = S_OFF;
                            restart = 1'b1;
                            if (pat_q != 2'd2) beep_d = beep_q - 2'd1;
                        end
                    end else begin
                        state_d = S_ON;
                        restart = 1'b1;
                    end
                end
            end
        endcase

        if (start) begin
            state_d = S_ON;
            pat_d   = hi_idx;
            restart = 1'b1;
            case (hi_idx)
                2'd0:    beep_d = 2'd1;
                2'd1:    beep_d = 2'd2;
                default: beep_d = 2'd0;
            endcase
        end
        if (to_idle) begin
            state_d = S_IDLE;
            pat_d   = 2'd0;
            beep_d  = 2'd0;
        end

        // Repeat requests for the running pattern are dropped; stop wins over req[2]
        pend_d = (pend_q | (req & ~run_mask)) & ~{stop, 2'b00};
        if (start) pend_d[hi_idx] = 1'b0;

        pre_d = '0;
        ms_d  = '0;
        hp_d  = '0;
        buz_d = 1'b0;
        if (!restart && state_d != S_IDLE) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
            ms_d  = tick ? ms_q + 8'd1 : ms_q;
            if (state_q == S_ON) begin
                if (hp_q == hp_last) begin
                    hp_d  = '0;
                    buz_d = ~buz_q;
                end else begin
                    hp_d  = hp_q + 1'b1;
                    buz_d = buz_q;
                end
            end
        end
    end

    // State and counter registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pat_q   <= 2'd0;
            pend_q  <= 3'b000;
            pre_q   <= '0;
            ms_q    <= '0;
            hp_q    <= '0;
            beep_q  <= 2'd0;
            buz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            state_q <= state_d;
            pat_q   <= pat_d;
            pend_q  <= pend_d;
            pre_q   <= pre_d;
            ms_q    <= ms_d;
            hp_q    <= hp_d;
            beep_q  <= beep_d;
            buz_q   <= buz_d;
            done_q  <= done_d;
        end
    end

    assign buz    = buz_q;
    assign done   = done_q;
    assign busy   = (state_q != S_IDLE);
    assign active = (state_q == S_IDLE) ? 2'd3 : pat_q;

endmodule

// File: tb/tb_buzz_ctrl.sv
// Self-checking bench for buzz_ctrl: a directed vector table, hand-written
// multi-cycle sequences, and random traffic against a timeline model that
// derives outputs from elapsed time since pattern start.
module tb_buzz_ctrl;

    localparam int TD = 10;
    localparam int H0 = 4;
    localparam int H1 = 5;
    localparam int H2 = 2;

    localparam int ON0  = 50 * TD;
    localparam int ON1  = 200 * TD;
    localparam int OFF1 = 100 * TD;
    localparam int ON2  = 100 * TD;
    localparam int OFF2 = 100 * TD;
    localparam int TOT0 = ON0;
    localparam int TOT1 = 2 * ON1 + OFF1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] req = 3'b000;
    logic       stop = 1'b0;
    logic       buz, busy, done;
    logic [1:0] active;

    buzz_ctrl #(.TICK_DIV(TD), .HP0(H0), .HP1(H1), .HP2(H2)) dut (
        .clk(clk), .rst(rst), .req(req), .stop(stop),
        .buz(buz), .busy(busy), .active(active), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit       m_busy;
    int       m_pat;
    int       m_t;
    bit [2:0] m_pend;
    bit       m_done;

    // Running statistics gathered by step()
    int g_busy, g_rise, g_done;
    bit g_pb;

    typedef struct {
        logic [2:0] r;
        logic       s;
        logic       busy;
        logic [1:0] act;
        logic       buz;
        logic       done;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_busy = 1'b0; m_pat = 0; m_t = 0; m_pend = 3'b000; m_done = 1'b0;
    endtask

    function automatic int hp_of(input int p);
        return (p == 0) ? H0 : (p == 1) ? H1 : H2;
    endfunction

    // Tone level from time since pattern start
    function automatic logic model_buz();
        int pos;
        bit on;
        int tt;
        if (!m_busy) return 1'b0;
        on = 1'b1;
        pos = m_t;
        if (m_pat == 1) begin
            if (m_t < ON1) pos = m_t;
            else if (m_t < ON1 + OFF1) on = 1'b0;
            else pos = m_t - ON1 - OFF1;
        end else if (m_pat == 2) begin
            tt = m_t % (ON2 + OFF2);
            if (tt < ON2) pos = tt;
            else on = 1'b0;
        end
        return on && (((pos / hp_of(m_pat)) % 2) == 1);
    endfunction

    task automatic model_edge(input logic [2:0] r, input logic s);
        bit [2:0] eff, runm, nxt;
        int hi, go;
        if (!rst) begin
            model_clear();
            return;
        end
        eff  = m_pend & ~{s, 2'b00};
        hi   = eff[2] ? 2 : eff[1] ? 1 : eff[0] ? 0 : -1;
        runm = m_busy ? (3'b001 << m_pat) : 3'b000;
        nxt  = (m_pend | (r & ~runm)) & ~{s, 2'b00};
        m_done = 1'b0;
        go = -1;
        if (!m_busy) begin
            go = hi;
        end else if (m_pat == 2 && s) begin
            if (hi >= 0) go = hi; else m_busy = 1'b0;
        end else if (hi > m_pat) begin
            go = hi;
        end else begin
            m_t++;
            if (m_pat == 2) begin
                m_t = m_t % (ON2 + OFF2);
            end else if (m_t == ((m_pat == 0) ? TOT0 : TOT1)) begin
                m_done = 1'b1;
                if (hi >= 0) go = hi; else m_busy = 1'b0;
            end
        end
        if (go >= 0) begin
            m_busy = 1'b1; m_pat = go; m_t = 0; nxt[go] = 1'b0;
        end
        m_pend = nxt;
    endtask

    task automatic step(input logic [2:0] r, input logic s);
        logic [1:0] ea;
        req = r; stop = s;
        @(posedge clk);
        model_edge(r, s);
        #1;
        ea = m_busy ? 2'(m_pat) : 2'd3;
        check("model", {27'd0, buz, busy, active, done},
              {27'd0, model_buz(), m_busy, ea, m_done});
        if (busy) g_busy++;
        if (buz && !g_pb) g_rise++;
        g_pb = buz;
        if (done) g_done++;
        req = 3'b000; stop = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {27'd0, buz, busy, active, done}, {27'd0, 5'b0_0_11_0});
        rst = 1'b1;
        g_busy = 0; g_rise = 0; g_done = 0; g_pb = 1'b0;
    endtask

    // Step until idle; count busy cycles, buz rises, done pulses, buz-high cycles in a window
    task automatic run_idle(input string name, input int max_cyc, input int w_lo, input int w_hi,
                            output int nb, output int nr, output int nd, output int nw);
        bit pb, idle;
        nb = 0; nr = 0; nd = 0; nw = 0; pb = buz; idle = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            step(3'b000, 1'b0);
            if (busy && buz && nb >= w_lo && nb < w_hi) nw++;
            if (busy) nb++;
            if (buz && !pb) nr++;
            pb = buz;
            if (done) nd++;
            if (!busy) begin
                idle = 1'b1;
                break;
            end
        end
        check({name, "_reached_idle"}, {31'd0, idle}, 32'd1);
    endtask

    initial begin
        int nb, nr, nd, nw, idx;
        logic [2:0] r;
        logic s;

        // busy, active, buz, done expected after each edge
        vecs[0]  = '{3'b001, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0}; // req0 only pends
        vecs[1]  = '{3'b000, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0}; // P0 starts
        vecs[2]  = '{3'b100, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0}; // req2 pends
        vecs[3]  = '{3'b000, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0}; // P2 preempts
        vecs[4]  = '{3'b001, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0}; // req0 pends
        vecs[5]  = '{3'b000, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0}; // stop -> P0
        vecs[6]  = '{3'b000, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
        vecs[7]  = '{3'b110, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0}; // stop kills req2
        vecs[8]  = '{3'b000, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0}; // P1 preempts
        vecs[9]  = '{3'b010, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0}; // repeat ignored
        vecs[10] = '{3'b000, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0}; // stop irrelevant to P1
        vecs[11] = '{3'b101, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0};
        vecs[12] = '{3'b000, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0}; // P2 preempts P1

        do_reset();
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].r, vecs[i].s);
            check($sformatf("vec%0d", i), {28'd0, busy, active, buz, done},
                  {28'd0, vecs[i].busy, vecs[i].act, vecs[i].buz, vecs[i].done});
        end

        // Single key click
        do_reset();
        step(3'b001, 1'b0);
        check("p0_latency_busy", {31'd0, busy}, 32'd0);
        run_idle("p0", 1000, 0, 0, nb, nr, nd, nw);
        check("p0_busy_cycles", nb, ON0);
        check("p0_buz_rises", nr, 62);
        check("p0_done_pulses", nd, 1);
        check("p0_active_idle", {30'd0, active}, 32'd3);

        // Error double beep
        do_reset();
        step(3'b010, 1'b0);
        run_idle("p1", 6000, ON1, ON1 + OFF1, nb, nr, nd, nw);
        check("p1_busy_cycles", nb, TOT1);
        check("p1_buz_rises", nr, 2 * (ON1 / (2 * H1)));
        check("p1_off_buz_high", nw, 0);
        check("p1_done_pulses", nd, 1);

        // P0 preempted by alarm, then alarm stopped
        do_reset();
        step(3'b001, 1'b0);
        repeat (100) step(3'b000, 1'b0);
        step(3'b100, 1'b0);
        check("pre_active_still0", {30'd0, active}, 32'd0);
        step(3'b000, 1'b0);
        check("pre_active2", {30'd0, active}, 32'd2);
        g_rise = 0;
        repeat (400) step(3'b000, 1'b0);
        check("p2_rises_400", g_rise, 400 / (2 * H2));
        repeat (2496) step(3'b000, 1'b0);
        step(3'b000, 1'b1);
        check("stop_idle", {29'd0, busy, active}, {29'd0, 3'b0_11});
        check("stop_buz0", {31'd0, buz}, 32'd0);
        check("preempt_no_done", g_done, 0);

        // Alarm with a click waiting behind it
        do_reset();
        step(3'b100, 1'b0);
        repeat (50) step(3'b000, 1'b0);
        step(3'b001, 1'b0);
        repeat (200) step(3'b000, 1'b0);
        check("p2_holds_pend0", {30'd0, active}, 32'd2);
        step(3'b000, 1'b1);
        check("after_stop_p0", {30'd0, busy, active}, {29'd0, 3'b1_00});
        run_idle("p0_after_stop", 1000, 0, 0, nb, nr, nd, nw);
        check("p0_after_stop_cycles", nb + 1, ON0);
        check("p0_after_stop_done", nd, 1);

        // Simultaneous requests: P1 then P0 back to back
        do_reset();
        step(3'b011, 1'b0);
        idx = -1;
        for (int i = 1; i <= 6000; i++) begin
            step(3'b000, 1'b0);
            if (done) begin
                idx = i;
                break;
            end
        end
        check("p1_done_index", idx, TOT1 + 1);
        check("p0_follows_p1", {29'd0, busy, active}, {29'd0, 3'b1_00});
        run_idle("p0_follow", 1000, 0, 0, nb, nr, nd, nw);
        check("p0_follow_cycles", nb, ON0 - 1);
        check("both_done", g_done, 2);

        // Reset mid-beep
        do_reset();
        step(3'b010, 1'b0);
        repeat (307) step(3'b000, 1'b0);
        check("pre_rst_buz_high", {31'd0, buz}, 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_outputs", {27'd0, buz, busy, active, done}, {27'd0, 5'b0_0_11_0});
        model_clear();
        step(3'b011, 1'b0);
        step(3'b100, 1'b1);
        step(3'b000, 1'b0);
        rst = 1'b1;
        g_busy = 0;
        repeat (100) step(3'b000, 1'b0);
        check("no_resume_after_rst", g_busy, 0);
        step(3'b001, 1'b0);
        step(3'b000, 1'b0);
        check("first_req_after_rst", {29'd0, busy, active}, {29'd0, 3'b1_00});

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 20000; i++) begin
            r = {3{1'b0}};
            r[0] = ($urandom_range(299) == 0);
            r[1] = ($urandom_range(399) == 0);
            r[2] = ($urandom_range(599) == 0);
            s = ($urandom_range(1499) == 0);
            step(r, s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
